// File: rtl/ccip_rd_port_mux.sv
// N-port round-robin read-request mux onto one MPF c0 channel pair.
// Optional perf counters: define CCIP_RD_PORT_MUX_PERF_EN.
module ccip_rd_port_mux #(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_W          = 42,
    parameter int MDATA_W         = 12,
    parameter int DATA_W          = 512,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]    req_addr,
    input  logic [NUM_PORTS*MDATA_W-1:0]   req_mdata,
    output logic [NUM_PORTS-1:0]           req_ready,
    output logic                           tx_valid,
    output logic [ADDR_W-1:0]              tx_addr,
    output logic [15:0]                    tx_mdata,
    input  logic                           tx_almfull,
    input  logic                           rx_valid,
    input  logic [15:0]                    rx_mdata,
    input  logic [DATA_W-1:0]              rx_data,
    output logic [NUM_PORTS-1:0]           rsp_valid,
    output logic [MDATA_W-1:0]             rsp_mdata,
    output logic [DATA_W-1:0]              rsp_data,
    input  logic                           drain_req,
    output logic                           drain_done,
    output logic                           err_bad_tag,
    output logic                           err_underflow
`ifdef CCIP_RD_PORT_MUX_PERF_EN
    ,
    output logic [NUM_PORTS*32-1:0]        perf_req_cnt,
    output logic [31:0]                    perf_stall_cnt
`endif
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } state_t;

    state_t               state;
    state_t               stateNext;
    logic                 runOk;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        grantIdx;
    logic                 grantAny;
    logic [NUM_PORTS-1:0] grantVec;
    logic [NUM_PORTS-1:0] elig;
    logic [PW-1:0]        rxTag;
    logic                 tagOk;
    logic [NUM_PORTS-1:0] rxHit;
    logic [NUM_PORTS-1:0] cntZero;
    logic                 allZero;
    logic [15:0]          txMd;
    logic [CW-1:0]        cnt [NUM_PORTS];
    int                   idx;

    // Padding bits and the tag are folded in; only routing uses the tag.
    wire unusedRx = ^rx_mdata;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cntZero[i] = (cnt[i] == '0);
            elig[i] = req_valid[i] && !tx_almfull && runOk &&
                      (cnt[i] < CW'(MAX_OUTSTANDING));
        end
        allZero = &cntZero;
    end

    // Rotating search starting at ptr.
    always_comb begin
        grantAny = 1'b0;
        grantIdx = '0;
        idx      = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!grantAny && elig[idx]) begin
                grantAny = 1'b1;
                grantIdx = PW'(idx);
            end
        end
    end

    always_comb begin
        grantVec = '0;
        if (grantAny) grantVec = NUM_PORTS'(1) << grantIdx;
    end

    assign req_ready = grantVec & {NUM_PORTS{rst_n}};

    always_comb begin
        txMd = '0;
        txMd[MDATA_W-1:0] = req_mdata[int'(grantIdx)*MDATA_W +: MDATA_W];
        txMd[15 -: PW] = grantIdx;
    end

    assign rxTag = rx_mdata[15 -: PW];
    assign tagOk = {1'b0, rxTag} < (PW+1)'(NUM_PORTS);

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rxHit[i] = rx_valid && tagOk && (rxTag == PW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            RUN:     if (drain_req) stateNext = DRAIN;
            DRAIN: begin
                if (!drain_req) stateNext = RUN;
                else if (allZero && !rx_valid) stateNext = IDLE;
            end
            IDLE:    if (!drain_req) stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end

    always_comb begin
        runOk      = (state == RUN) && !drain_req;
        drain_done = (state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grantAny) begin
            if (int'(grantIdx) == NUM_PORTS - 1) ptr <= '0;
            else ptr <= grantIdx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid <= 1'b0;
            tx_addr  <= '0;
            tx_mdata <= '0;
        end else begin
            tx_valid <= grantAny;
            if (grantAny) begin
                tx_addr  <= req_addr[int'(grantIdx)*ADDR_W +: ADDR_W];
                tx_mdata <= txMd;
            end
        end
    end

    // A grant and a response on the same port cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grantVec[i] && !(rxHit[i] && !cntZero[i])) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else if (!grantVec[i] && rxHit[i] && !cntZero[i]) begin
                    cnt[i] <= cnt[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid     <= '0;
            rsp_mdata     <= '0;
            rsp_data      <= '0;
            err_bad_tag   <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            rsp_valid <= rxHit;
            if (|rxHit) begin
                rsp_mdata <= rx_mdata[MDATA_W-1:0];
                rsp_data  <= rx_data;
            end
            if (rx_valid && !tagOk) err_bad_tag <= 1'b1;
            if (|(rxHit & cntZero)) err_underflow <= 1'b1;
        end
    end

`ifdef CCIP_RD_PORT_MUX_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_req_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grantVec[i]) begin
                    perf_req_cnt[i*32 +: 32] <= perf_req_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if (|req_valid && !grantAny) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ccip_rd_port_mux.sv
// Directed self-checking bench for ccip_rd_port_mux.
// Second 5-port instance exercises out-of-range tags.
module tb_ccip_rd_port_mux;

    localparam int N  = 4;
    localparam int AW = 42;
    localparam int MW = 12;
    localparam int DW = 512;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*MW-1:0] req_mdata;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [AW-1:0]   tx_addr;
    logic [15:0]     tx_mdata;
    logic            tx_almfull;
    logic            rx_valid;
    logic [15:0]     rx_mdata;
    logic [DW-1:0]   rx_data;
    logic [N-1:0]    rsp_valid;
    logic [MW-1:0]   rsp_mdata;
    logic [DW-1:0]   rsp_data;
    logic            drain_req;
    logic            drain_done;
    logic            err_bad_tag;
    logic            err_underflow;

    logic [4:0]      b_ready;
    logic            b_tx_valid;
    logic [AW-1:0]   b_tx_addr;
    logic [15:0]     b_tx_mdata;
    logic            b_rx_valid;
    logic [15:0]     b_rx_mdata;
    logic [4:0]      b_rsp_valid;
    logic [MW-1:0]   b_rsp_mdata;
    logic [DW-1:0]   b_rsp_data;
    logic            b_drain_done;
    logic            b_bad_tag;
    logic            b_underflow;

    int checks   = 0;
    int failures = 0;
    int grants;

    always #5 clk = ~clk;

    ccip_rd_port_mux #(
        .NUM_PORTS(N), .ADDR_W(AW), .MDATA_W(MW),
        .DATA_W(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_mdata(req_mdata), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_addr(tx_addr),
        .tx_mdata(tx_mdata), .tx_almfull(tx_almfull),
        .rx_valid(rx_valid), .rx_mdata(rx_mdata),
        .rx_data(rx_data), .rsp_valid(rsp_valid),
        .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
        .drain_req(drain_req), .drain_done(drain_done),
        .err_bad_tag(err_bad_tag), .err_underflow(err_underflow)
    );

    ccip_rd_port_mux #(
        .NUM_PORTS(5), .ADDR_W(AW), .MDATA_W(MW),
        .DATA_W(DW), .MAX_OUTSTANDING(MO)
    ) dut5 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(5'b0), .req_addr({5*AW{1'b0}}),
        .req_mdata({5*MW{1'b0}}), .req_ready(b_ready),
        .tx_valid(b_tx_valid), .tx_addr(b_tx_addr),
        .tx_mdata(b_tx_mdata), .tx_almfull(1'b0),
        .rx_valid(b_rx_valid), .rx_mdata(b_rx_mdata),
        .rx_data(rx_data), .rsp_valid(b_rsp_valid),
        .rsp_mdata(b_rsp_mdata), .rsp_data(b_rsp_data),
        .drain_req(1'b0), .drain_done(b_drain_done),
        .err_bad_tag(b_bad_tag), .err_underflow(b_underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rsp(input logic [15:0] m);
        rx_valid = 1'b1;
        rx_mdata = m;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        #2;
        checks++;
        if (req_ready !== 4'h0) begin
            failures++;
            $display("FAIL rst_ready got=%h exp=0", req_ready);
        end
        checks++;
        if ({tx_valid, tx_mdata, rsp_valid} !== '0) begin
            failures++;
            $display("FAIL rst_out got=%b/%h/%b exp=0",
                     tx_valid, tx_mdata, rsp_valid);
        end
        checks++;
        if ({drain_done, err_bad_tag, err_underflow} !== 3'b000) begin
            failures++;
            $display("FAIL rst_flags got=%b exp=000",
                     {drain_done, err_bad_tag, err_underflow});
        end
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp [5];
        exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (req_ready !== (4'b1 << exp[k])) begin
                failures++;
                $display("FAIL rr_ready[%0d] got=%b exp=%b",
                         k, req_ready, 4'b1 << exp[k]);
            end
            tick();
            if (k == 4) req_valid = '0;
            checks++;
            if (!tx_valid || tx_mdata[15:14] !== exp[k] ||
                tx_addr !== AW'(42'h1000 + exp[k])) begin
                failures++;
                $display("FAIL rr_tx[%0d] got=%b/%h/%h exp tag=%0d",
                         k, tx_valid, tx_mdata, tx_addr, exp[k]);
            end
        end
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle got=%b exp=0", tx_valid);
        end
        send_rsp(16'h0000);
        send_rsp(16'h0000);
        send_rsp(16'h4000);
        send_rsp(16'h8000);
        send_rsp(16'hC000);
    endtask

    task automatic test_tag_routing();
        logic [DW-1:0] d;
        d = {16{32'hA5C3_0F1E}};
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL tag_ready got=%b exp=0100", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (!tx_valid || tx_mdata !== 16'h83A5) begin
            failures++;
            $display("FAIL tag_tx got=%b/%h exp=1/83a5", tx_valid, tx_mdata);
        end
        rx_data = d;
        send_rsp(16'h83A5);
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_mdata !== 12'h3A5 || rsp_data !== d) begin
            failures++;
            $display("FAIL tag_rsp got=%b/%h exp=0100/3a5", rsp_valid, rsp_mdata);
        end
        checks++;
        if (err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL tag_noufl got=%b exp=0", err_underflow);
        end
        tick();
        checks++;
        if (rsp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL tag_strobe got=%b exp=0000", rsp_valid);
        end
        send_rsp(16'h8000);
        checks++;
        if (err_underflow !== 1'b1) begin
            failures++;
            $display("FAIL tag_ufl got=%b exp=1", err_underflow);
        end
    endtask

    task automatic test_limit();
        req_valid = 4'b0010;
        grants = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (req_ready[1]) grants++;
            tick();
        end
        checks++;
        if (grants != 4) begin
            failures++;
            $display("FAIL lim_cap got=%0d exp=4", grants);
        end
        send_rsp(16'h4000);
        grants = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (req_ready[1]) grants++;
            tick();
        end
        req_valid = '0;
        checks++;
        if (grants != 1) begin
            failures++;
            $display("FAIL lim_reopen got=%0d exp=1", grants);
        end
        for (int k = 0; k < 4; k++) send_rsp(16'h4000);
    endtask

    task automatic test_simultaneous();
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) tick();
        rx_valid = 1'b1;
        rx_mdata = 16'h0000;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL sim_ready got=%b exp=0001", req_ready);
        end
        tick();
        rx_valid = 1'b0;
        checks++;
        if (rsp_valid !== 4'b0001) begin
            failures++;
            $display("FAIL sim_rsp got=%b exp=0001", rsp_valid);
        end
        grants = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (req_ready[0]) grants++;
            tick();
        end
        req_valid = '0;
        checks++;
        if (grants != 1) begin
            failures++;
            $display("FAIL sim_cnt got=%0d exp=1", grants);
        end
        for (int k = 0; k < 4; k++) send_rsp(16'h0000);
    endtask

    task automatic test_almfull();
        req_valid = 4'hF;
        tick();
        tx_almfull = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL af_ready got=%b exp=0000", req_ready);
        end
        checks++;
        if (!tx_valid || tx_mdata[15:14] !== 2'd1) begin
            failures++;
            $display("FAIL af_issue got=%b/%h exp tag=1", tx_valid, tx_mdata);
        end
        tick();
        checks++;
        if (tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL af_stop got=%b exp=0", tx_valid);
        end
        tx_almfull = 1'b0;
        req_valid = '0;
        send_rsp(16'h4000);
    endtask

    task automatic test_drain();
        logic [15:0] tags [4];
        tags = '{16'h0000, 16'h4000, 16'h8000, 16'h8000};
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) tick();
        drain_req = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL dr_block got=%b exp=0000", req_ready);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            send_rsp(tags[k]);
            #1;
            checks++;
            if (req_ready !== 4'b0000 || drain_done !== 1'b0) begin
                failures++;
                $display("FAIL dr_hold[%0d] got=%b/%b exp=0000/0",
                         k, req_ready, drain_done);
            end
        end
        send_rsp(16'hC000);
        checks++;
        if (drain_done !== 1'b0) begin
            failures++;
            $display("FAIL dr_early got=%b exp=0", drain_done);
        end
        tick();
        checks++;
        if (drain_done !== 1'b1) begin
            failures++;
            $display("FAIL dr_done got=%b exp=1", drain_done);
        end
        drain_req = 1'b0;
        tick();
        checks++;
        if (drain_done !== 1'b0 || req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL dr_resume got=%b/%b exp=0/1000", drain_done, req_ready);
        end
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_mdata[15:14] !== 2'd3) begin
            failures++;
            $display("FAIL dr_tx got=%b/%h exp tag=3", tx_valid, tx_mdata);
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_valid, tx_addr, tx_mdata, req_ready, rsp_valid} !== '0) begin
            failures++;
            $display("FAIL arst_out got=%b/%h/%h/%b exp=0",
                     tx_valid, tx_mdata, req_ready, rsp_valid);
        end
        checks++;
        if ({err_underflow, drain_done} !== 2'b00) begin
            failures++;
            $display("FAIL arst_flags got=%b exp=00", {err_underflow, drain_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL arst_ptr got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = '0;
        checks++;
        if (!tx_valid || tx_mdata[15:14] !== 2'd0) begin
            failures++;
            $display("FAIL arst_tx got=%b/%h exp tag=0", tx_valid, tx_mdata);
        end
        send_rsp(16'h0000);
    endtask

    task automatic test_drain_idle();
        drain_req = 1'b1;
        tick();
        checks++;
        if (drain_done !== 1'b0) begin
            failures++;
            $display("FAIL di_mid got=%b exp=0", drain_done);
        end
        tick();
        checks++;
        if (drain_done !== 1'b1) begin
            failures++;
            $display("FAIL di_done got=%b exp=1", drain_done);
        end
        drain_req = 1'b0;
        tick();
        checks++;
        if (drain_done !== 1'b0) begin
            failures++;
            $display("FAIL di_exit got=%b exp=0", drain_done);
        end
    endtask

    task automatic test_bad_tag();
        checks++;
        if (b_bad_tag !== 1'b0) begin
            failures++;
            $display("FAIL bt_pre got=%b exp=0", b_bad_tag);
        end
        b_rx_valid = 1'b1;
        b_rx_mdata = 16'hA123;
        tick();
        b_rx_valid = 1'b0;
        checks++;
        if (b_rsp_valid !== 5'b0 || b_bad_tag !== 1'b1) begin
            failures++;
            $display("FAIL bt_drop got=%b/%b exp=00000/1", b_rsp_valid, b_bad_tag);
        end
        checks++;
        if (b_underflow !== 1'b0) begin
            failures++;
            $display("FAIL bt_nocnt got=%b exp=0", b_underflow);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        tx_almfull = 1'b0;
        rx_valid   = 1'b0;
        rx_mdata   = '0;
        rx_data    = '0;
        drain_req  = 1'b0;
        b_rx_valid = 1'b0;
        b_rx_mdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = AW'(42'h1000 + i);
            req_mdata[i*MW +: MW] = MW'(12'h100 + i);
        end
        req_mdata[2*MW +: MW] = 12'h3A5;
        test_reset();
        test_round_robin();
        test_tag_routing();
        test_limit();
        test_simultaneous();
        test_almfull();
        test_drain();
        test_reset_mid();
        test_drain_idle();
        test_bad_tag();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
